gsu_mem_arbiter: RTL and testbench
==================================

GSU_MEM_ARBITER -- requirements
Module: gsu_mem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 4: clock cycles the memory port is held per access (legal 2..15).
REQ-002 Parameter STARVE_LIMIT, default 8: consecutive lost arbitrations after which MCU is promoted.
REQ-003 Port CLK  in  1  sole clock; all logic rising-edge.
REQ-004 Port RST_N  in  1  reset, synchronous, active-low.
REQ-005 Ports SNES_REQ / GSU_REQ / MCU_REQ  in  1 each  access requests, held high until matching ACK.
REQ-006 Ports SNES_ADDR / GSU_ADDR / MCU_ADDR  in  24 each  decoded memory address (ROM or save-RAM space) per requester.
REQ-007 Ports SNES_WE / GSU_WE / MCU_WE  in  1 each  write strobe qualifier; WDATA_x  in  8 each  write data.
REQ-008 Ports SNES_ACK / GSU_ACK / MCU_ACK  out  1 each  single-cycle completion pulse.
REQ-009 Port RDATA  out  8  read data, valid in the ACK cycle, held until the next ACK.
REQ-010 Ports MEM_ADDR  out  24, MEM_OE_N  out  1, MEM_WE_N  out  1, MEM_DOUT  out  8, MEM_DIN  in  8: external memory port.
REQ-011 Port GSU_OWNS_ROM  in  1  GSU RON flag; when high, SNES ROM (non-save-RAM) requests are not granted.
REQ-012 Port IS_SAVERAM_SNES  in  1  SNES request targets save-RAM.
REQ-013 Port BUSY  out  1  high while state is not IDLE.

Function
REQ-014 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on grant, ACCESS->DONE when cycle counter reaches ACCESS_CYCLES-1, DONE->IDLE unconditionally.
REQ-015 Grant evaluated only in IDLE; fixed priority SNES > GSU > MCU, except MCU wins over GSU when starve counter equals STARVE_LIMIT.
REQ-016 SNES ROM request with GSU_OWNS_ROM=1 is ineligible; save-RAM requests (IS_SAVERAM_SNES=1) remain eligible.
REQ-017 On grant, MEM_ADDR, MEM_DOUT and write flag latched from winner; inputs ignored thereafter until DONE.
REQ-018 Read: MEM_OE_N low for all ACCESS cycles; RDATA captured from MEM_DIN on the final ACCESS cycle.
REQ-019 Write: MEM_WE_N low on ACCESS cycles 1..ACCESS_CYCLES-2 only (address setup/hold one cycle each side); MEM_OE_N stays high.
REQ-020 ACK for the granted requester asserted exactly in DONE; grant-to-ACK latency = ACCESS_CYCLES+1 cycles.
REQ-021 Back-to-back: a request still pending in DONE is granted in the following IDLE cycle; minimum access period ACCESS_CYCLES+2.
REQ-022 Starve counter: 4 bits, increments (saturating at STARVE_LIMIT) each grant to another requester while MCU_REQ high; clears on MCU grant or MCU_REQ low.
REQ-023 Request dropped mid-access: access completes, ACK still pulsed; no abort.
REQ-024 GSU_OWNS_ROM changing mid-access does not affect the access in flight.

Reset
REQ-025 With RST_N low at a clock edge: state IDLE, counters 0, all ACK 0, BUSY 0, MEM_OE_N 1, MEM_WE_N 1, MEM_ADDR 0, MEM_DOUT 0, RDATA 0.
REQ-026 Reset mid-access abandons it without ACK; MEM_WE_N high in the first cycle after the reset edge.

Configuration
REQ-027 Macro GSU_ARB_STARVE_GUARD_EN defined: REQ-015/REQ-022 promotion active.
REQ-028 Macro undefined: starve counter absent, strict fixed priority SNES > GSU > MCU.

Structure
REQ-029 Shared package gsu_mem_pkg holds the state enum, requester ID encoding (NONE, SNES, GSU, MCU) and ACCESS_CYCLES default.
REQ-030 One sub-module, gsu_arb_pick: combinational priority/eligibility selector returning requester ID; FSM, counters and datapath stay in gsu_mem_arbiter.

Verification
REQ-031 SNES read 0x008000, MEM_DIN=0xA5, defaults -> MEM_OE_N low 4 cycles, SNES_ACK at cycle 5, RDATA=0xA5.
REQ-032 SNES, GSU, MCU requests same cycle -> ACK order SNES, GSU, MCU, each 6 cycles apart.
REQ-033 GSU_OWNS_ROM=1, SNES ROM read and save-RAM write 0xE00010 queued with GSU -> ROM read waits until flag low; save-RAM write granted before GSU.
REQ-034 Guard enabled, GSU_REQ always high, MCU_REQ high -> MCU granted after 8 GSU grants; guard disabled -> MCU never granted.
REQ-035 MCU write 0x5A to 0xE00000 -> MEM_WE_N low cycles 2-3 of ACCESS only, MEM_DOUT=0x5A throughout.
REQ-036 RST_N low during ACCESS cycle 2 of a write -> no ACK, MEM_WE_N high next cycle, all outputs at reset values.

Source files
------------

// File: rtl/gsu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : gsu_mem_pkg
// Brief  : Shared state encoding, requester IDs and defaults for the GSU
//          memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package gsu_mem_pkg;

    localparam int c_ACCESS_CYCLES_DEFAULT = 4;

    typedef logic [1:0] arb_state_t;
    typedef logic [1:0] req_id_t;

    localparam arb_state_t c_ST_IDLE   = 2'd0;
    localparam arb_state_t c_ST_ACCESS = 2'd1;
    localparam arb_state_t c_ST_DONE   = 2'd2;

    localparam req_id_t c_ID_NONE = 2'd0;
    localparam req_id_t c_ID_SNES = 2'd1;
    localparam req_id_t c_ID_GSU  = 2'd2;
    localparam req_id_t c_ID_MCU  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gsu_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : gsu_arb_pick
// Brief  : Combinational eligibility filter and priority selector; returns
//          the ID of the requester that would win arbitration this cycle.
// Rev    : 1.0  initial release
// ============================================================================
module gsu_arb_pick
    import gsu_mem_pkg::*;
(
    input  logic    i_snes_req,
    input  logic    i_gsu_req,
    input  logic    i_mcu_req,
    input  logic    i_gsu_owns_rom,
    input  logic    i_is_saveram_snes,
    input  logic    i_starve_hit,
    output req_id_t o_winner
);

    logic w_snes_ok;

    // While the GSU holds ROM, the SNES may still reach save-RAM
    assign w_snes_ok = i_snes_req && (!i_gsu_owns_rom || i_is_saveram_snes);

    always_comb begin
        o_winner = c_ID_NONE;
        if (w_snes_ok) begin
            o_winner = c_ID_SNES;
        end else if (i_mcu_req && i_starve_hit) begin
            o_winner = c_ID_MCU;
        end else if (i_gsu_req) begin
            o_winner = c_ID_GSU;
        end else if (i_mcu_req) begin
            o_winner = c_ID_MCU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : gsu_mem_arbiter
// Brief  : Three-way (SNES / GSU / MCU) arbiter for a shared 8-bit external
//          ROM / save-RAM port with fixed-length access timing.
// Config : define GSU_ARB_STARVE_GUARD_EN to promote a starved MCU over GSU.
// Rev    : 1.0  initial release
// ============================================================================
module gsu_mem_arbiter
    import gsu_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = c_ACCESS_CYCLES_DEFAULT,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        SNES_REQ,
    input  logic        GSU_REQ,
    input  logic        MCU_REQ,
    input  logic [23:0] SNES_ADDR,
    input  logic [23:0] GSU_ADDR,
    input  logic [23:0] MCU_ADDR,
    input  logic        SNES_WE,
    input  logic        GSU_WE,
    input  logic        MCU_WE,
    input  logic [7:0]  WDATA_SNES,
    input  logic [7:0]  WDATA_GSU,
    input  logic [7:0]  WDATA_MCU,

    output logic        SNES_ACK,
    output logic        GSU_ACK,
    output logic        MCU_ACK,
    output logic [7:0]  RDATA,

    output logic [23:0] MEM_ADDR,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic [7:0]  MEM_DOUT,
    input  logic [7:0]  MEM_DIN,

    input  logic        GSU_OWNS_ROM,
    input  logic        IS_SAVERAM_SNES,
    output logic        BUSY
);

    localparam logic [3:0] c_LAST_CNT = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] c_WE_END   = 4'(ACCESS_CYCLES - 2);

    if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("ACCESS_CYCLES must be within 2..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    req_id_t     r_owner;
    logic        r_we;
    logic        w_next_we;
    logic        w_grant;
    logic        w_starve_hit;
    req_id_t     w_pick;
    logic [23:0] w_win_addr;
    logic [7:0]  w_win_wdata;
    logic        w_win_we;

    gsu_arb_pick u_pick (
        .i_snes_req        (SNES_REQ),
        .i_gsu_req         (GSU_REQ),
        .i_mcu_req         (MCU_REQ),
        .i_gsu_owns_rom    (GSU_OWNS_ROM),
        .i_is_saveram_snes (IS_SAVERAM_SNES),
        .i_starve_hit      (w_starve_hit),
        .o_winner          (w_pick)
    );

`ifdef GSU_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    // Counts arbitrations the MCU lost while it was actually waiting
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_starve_cnt <= 4'd0;
        end else if (!MCU_REQ) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant) begin
            if (w_pick == c_ID_MCU) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign w_starve_hit = (r_starve_cnt == c_STARVE_MAX);
`else
    assign w_starve_hit = 1'b0;
`endif

    always_comb begin
        w_win_addr  = 24'd0;
        w_win_wdata = 8'd0;
        w_win_we    = 1'b0;
        case (w_pick)
            c_ID_SNES: begin
                w_win_addr  = SNES_ADDR;
                w_win_wdata = WDATA_SNES;
                w_win_we    = SNES_WE;
            end
            c_ID_GSU: begin
                w_win_addr  = GSU_ADDR;
                w_win_wdata = WDATA_GSU;
                w_win_we    = GSU_WE;
            end
            c_ID_MCU: begin
                w_win_addr  = MCU_ADDR;
                w_win_wdata = WDATA_MCU;
                w_win_we    = MCU_WE;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_grant      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_pick != c_ID_NONE) begin
                    w_next_state = c_ST_ACCESS;
                    w_next_cnt   = 4'd0;
                    w_grant      = 1'b1;
                end
            end
            c_ST_ACCESS: begin
                if (r_cnt == c_LAST_CNT) begin
                    w_next_state = c_ST_DONE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt   = r_cnt + 4'd1;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    assign w_next_we = w_grant ? w_win_we : r_we;

    // Strobes are registered from next-state values so they line up exactly
    // with the ACCESS cycles; WE leaves one cycle of address setup and hold.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 4'd0;
            r_owner  <= c_ID_NONE;
            r_we     <= 1'b0;
            MEM_ADDR <= 24'd0;
            MEM_DOUT <= 8'd0;
            MEM_OE_N <= 1'b1;
            MEM_WE_N <= 1'b1;
            RDATA    <= 8'd0;
            BUSY     <= 1'b0;
            SNES_ACK <= 1'b0;
            GSU_ACK  <= 1'b0;
            MCU_ACK  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_grant) begin
                r_owner  <= w_pick;
                r_we     <= w_win_we;
                MEM_ADDR <= w_win_addr;
                MEM_DOUT <= w_win_wdata;
            end
            MEM_OE_N <= !((w_next_state == c_ST_ACCESS) && !w_next_we);
            MEM_WE_N <= !((w_next_state == c_ST_ACCESS) && w_next_we &&
                          (w_next_cnt >= 4'd1) && (w_next_cnt <= c_WE_END));
            if ((r_state == c_ST_ACCESS) && (r_cnt == c_LAST_CNT) && !r_we) begin
                RDATA <= MEM_DIN;
            end
            BUSY     <= (w_next_state != c_ST_IDLE);
            SNES_ACK <= (w_next_state == c_ST_DONE) && (r_owner == c_ID_SNES);
            GSU_ACK  <= (w_next_state == c_ST_DONE) && (r_owner == c_ID_GSU);
            MCU_ACK  <= (w_next_state == c_ST_DONE) && (r_owner == c_ID_MCU);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_gsu_mem_arbiter
// Brief  : Scoreboard bench for gsu_mem_arbiter; expected ACKs are queued at
//          stimulus time and retired when the DUT acknowledges.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gsu_mem_arbiter;

    localparam int c_ACC    = 4;
    localparam int c_STARVE = 8;
    localparam int c_SNES   = 0;
    localparam int c_GSU    = 1;
    localparam int c_MCU    = 2;

    typedef struct {
        int          id;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        snes_req, gsu_req, mcu_req;
    logic [23:0] snes_addr, gsu_addr, mcu_addr;
    logic        snes_we, gsu_we, mcu_we;
    logic [7:0]  snes_wdata, gsu_wdata, mcu_wdata;
    logic        snes_ack, gsu_ack, mcu_ack;
    logic [7:0]  rdata;
    logic [23:0] mem_addr;
    logic        mem_oe_n, mem_we_n;
    logic [7:0]  mem_dout, mem_din;
    logic        gsu_owns_rom, is_saveram_snes, busy;

    exp_t        q[$];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          bidx;
    int          oe_cnt;
    logic [15:0] we_mask;
    logic [7:0]  dout_first;
    logic        dout_moved;
    logic        gsu_hold;
    logic [15:0] we_mask_exp;

    gsu_mem_arbiter #(
        .ACCESS_CYCLES (c_ACC),
        .STARVE_LIMIT  (c_STARVE)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .SNES_REQ        (snes_req),
        .GSU_REQ         (gsu_req),
        .MCU_REQ         (mcu_req),
        .SNES_ADDR       (snes_addr),
        .GSU_ADDR        (gsu_addr),
        .MCU_ADDR        (mcu_addr),
        .SNES_WE         (snes_we),
        .GSU_WE          (gsu_we),
        .MCU_WE          (mcu_we),
        .WDATA_SNES      (snes_wdata),
        .WDATA_GSU       (gsu_wdata),
        .WDATA_MCU       (mcu_wdata),
        .SNES_ACK        (snes_ack),
        .GSU_ACK         (gsu_ack),
        .MCU_ACK         (mcu_ack),
        .RDATA           (rdata),
        .MEM_ADDR        (mem_addr),
        .MEM_OE_N        (mem_oe_n),
        .MEM_WE_N        (mem_we_n),
        .MEM_DOUT        (mem_dout),
        .MEM_DIN         (mem_din),
        .GSU_OWNS_ROM    (gsu_owns_rom),
        .IS_SAVERAM_SNES (is_saveram_snes),
        .BUSY            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rd_data(input logic [23:0] a);
        if (a == 24'h008000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [23:0] a, input logic we,
                        input logic [7:0] wd, input int due);
        exp_t e;
        e.id = id; e.addr = a; e.we = we; e.wdata = wd; e.due = due;
        q.push_back(e);
    endtask

    // One clock: observe on the falling edge, retire ACKs, model the memory
    task automatic tick();
        logic [2:0] acks;
        exp_t       e;
        @(negedge clk);
        cyc++;
        if (busy) begin
            bidx++;
            if (!mem_oe_n) oe_cnt++;
            if (!mem_we_n && bidx < 16) we_mask[bidx] = 1'b1;
            if (bidx == 1) dout_first = mem_dout;
            else if (mem_dout !== dout_first) dout_moved = 1'b1;
        end else begin
            bidx = 0; oe_cnt = 0; we_mask = '0; dout_moved = 1'b0;
        end
        mem_din = (busy && !mem_oe_n && bidx == c_ACC) ? rd_data(mem_addr) : 8'hEE;
        acks = {snes_ack, gsu_ack, mcu_ack};
        if (acks != 3'b000) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {29'd0, acks}, 32'd0);
            end else begin
                e = q.pop_front();
                check("ack_id", {29'd0, acks}, {29'd0, 3'b100 >> e.id});
                check("ack_cycle", cyc, e.due);
                check("mem_addr", {8'd0, mem_addr}, {8'd0, e.addr});
                if (e.we) begin
                    check("wr_we_mask", {16'd0, we_mask}, {16'd0, we_mask_exp});
                    check("wr_oe_cnt", oe_cnt, 0);
                    check("wr_dout", {24'd0, mem_dout}, {24'd0, e.wdata});
                    check("wr_dout_stable", {31'd0, dout_moved}, 32'd0);
                end else begin
                    check("rd_rdata", {24'd0, rdata}, {24'd0, rd_data(e.addr)});
                    check("rd_oe_cnt", oe_cnt, c_ACC);
                    check("rd_we_mask", {16'd0, we_mask}, 32'd0);
                end
            end
            if (snes_ack) snes_req = 1'b0;
            if (gsu_ack && !gsu_hold) gsu_req = 1'b0;
            if (mcu_ack) mcu_req = 1'b0;
            bidx = 0; oe_cnt = 0; we_mask = '0; dout_moved = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 0);
            q.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_busy"},  {31'd0, busy}, 32'd0);
        check({pfx, "_acks"},  {29'd0, snes_ack, gsu_ack, mcu_ack}, 32'd0);
        check({pfx, "_oe_n"},  {31'd0, mem_oe_n}, 32'd1);
        check({pfx, "_we_n"},  {31'd0, mem_we_n}, 32'd1);
        check({pfx, "_addr"},  {8'd0, mem_addr}, 32'd0);
        check({pfx, "_dout"},  {24'd0, mem_dout}, 32'd0);
        check({pfx, "_rdata"}, {24'd0, rdata}, 32'd0);
    endtask

    initial begin
        int t;
        n_checks = 0; n_errors = 0; cyc = 0;
        bidx = 0; oe_cnt = 0; we_mask = '0; dout_first = 8'd0; dout_moved = 1'b0;
        gsu_hold = 1'b0;
        we_mask_exp = '0;
        for (int i = 2; i <= c_ACC - 1; i++) we_mask_exp[i] = 1'b1;
        rst_n = 1'b0;
        snes_req = 0; gsu_req = 0; mcu_req = 0;
        snes_addr = '0; gsu_addr = '0; mcu_addr = '0;
        snes_we = 0; gsu_we = 0; mcu_we = 0;
        snes_wdata = '0; gsu_wdata = '0; mcu_wdata = '0;
        mem_din = 8'hEE; gsu_owns_rom = 0; is_saveram_snes = 0;

        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Single SNES read with the default access length
        t = cyc;
        snes_addr = 24'h008000; snes_we = 0; snes_req = 1;
        push(c_SNES, 24'h008000, 1'b0, 8'h00, t + 5);
        drain(40);

        // Simultaneous requests retire in priority order, 6 cycles apart
        t = cyc;
        snes_addr = 24'h00C123; snes_we = 0; snes_req = 1;
        gsu_addr = 24'h700005; gsu_we = 1; gsu_wdata = 8'h77; gsu_req = 1;
        mcu_addr = 24'hE00200; mcu_we = 0; mcu_req = 1;
        push(c_SNES, 24'h00C123, 1'b0, 8'h00, t + 5);
        push(c_GSU,  24'h700005, 1'b1, 8'h77, t + 11);
        push(c_MCU,  24'hE00200, 1'b0, 8'h00, t + 17);
        drain(60);
        gsu_we = 0;

        // GSU owns ROM: SNES save-RAM write still beats GSU
        t = cyc;
        gsu_owns_rom = 1;
        snes_addr = 24'hE00010; snes_we = 1; snes_wdata = 8'h3C; is_saveram_snes = 1; snes_req = 1;
        gsu_addr = 24'h123456; gsu_we = 0; gsu_req = 1;
        push(c_SNES, 24'hE00010, 1'b1, 8'h3C, t + 5);
        push(c_GSU,  24'h123456, 1'b0, 8'h00, t + 11);
        drain(60);

        // GSU owns ROM: SNES ROM read waits until the flag drops
        t = cyc;
        is_saveram_snes = 0;
        snes_addr = 24'h018000; snes_we = 0; snes_req = 1;
        gsu_addr = 24'h234567; gsu_req = 1;
        push(c_GSU, 24'h234567, 1'b0, 8'h00, t + 5);
        while (cyc < t + 20) tick();
        check("rom_blocked", {30'd0, busy, snes_req}, 32'd1);
        gsu_owns_rom = 0;
        push(c_SNES, 24'h018000, 1'b0, 8'h00, cyc + 5);
        drain(40);

        // MCU write: WE strobe inside the access window only
        t = cyc;
        mcu_addr = 24'hE00000; mcu_we = 1; mcu_wdata = 8'h5A; mcu_req = 1;
        push(c_MCU, 24'hE00000, 1'b1, 8'h5A, t + 5);
        drain(40);
        mcu_we = 0;

        // GSU hammering the port while the MCU waits
        t = cyc;
        gsu_hold = 1;
        gsu_addr = 24'h345678; gsu_we = 0; gsu_req = 1;
        mcu_addr = 24'hE00300; mcu_we = 0; mcu_req = 1;
`ifdef GSU_ARB_STARVE_GUARD_EN
        for (int k = 0; k < c_STARVE; k++) push(c_GSU, 24'h345678, 1'b0, 8'h00, t + 5 + 6 * k);
        push(c_MCU, 24'hE00300, 1'b0, 8'h00, t + 53);
        push(c_GSU, 24'h345678, 1'b0, 8'h00, t + 59);
`else
        for (int k = 0; k < 9; k++) push(c_GSU, 24'h345678, 1'b0, 8'h00, t + 5 + 6 * k);
        push(c_MCU, 24'hE00300, 1'b0, 8'h00, t + 59);
`endif
        while (cyc < t + 50) tick();
        gsu_hold = 0;
        drain(200);

        // Reset during the second ACCESS cycle of a write
        mcu_addr = 24'hE00020; mcu_we = 1; mcu_wdata = 8'hC3; mcu_req = 1;
        tick();
        tick();
        check("rst_pre_we_n", {31'd0, mem_we_n}, 32'd0);
        rst_n = 1'b0;
        tick();
        check_reset_values("midrst");
        rst_n = 1'b1; mcu_req = 0; mcu_we = 0;
        repeat (12) tick();
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
